// File: rtl/p_div_pkg.sv
// Shared datatypes and helpers for the perceptron arithmetic units.
// Contents: dtype_t and dconf_t format descriptors, default port formats,
// and sat_max/sat_min, the saturation bounds for a given output format.
package p_div_pkg;

  typedef enum logic [1:0] {
    INT = 2'd0,
    FXP = 2'd1
  } dtype_t;

  // Number format: dtype, signedness, total bit width, fractional bits.
  typedef struct packed {
    dtype_t      dtype;
    logic        sign;
    int unsigned prec;
    int unsigned frac;
  } dconf_t;

  localparam dconf_t DEF_I1_CONF = '{dtype: FXP, sign: 1'b1, prec: 8,  frac: 3};
  localparam dconf_t DEF_I2_CONF = '{dtype: FXP, sign: 1'b1, prec: 8,  frac: 3};
  localparam dconf_t DEF_O_CONF  = '{dtype: FXP, sign: 1'b1, prec: 12, frac: 6};

  // Largest raw value representable in format c.
  function automatic longint sat_max(input dconf_t c);
    if (c.sign) return (64'sd1 <<< (c.prec - 1)) - 64'sd1;
    return (64'sd1 <<< c.prec) - 64'sd1;
  endfunction

  // Smallest raw value representable in format c.
  function automatic longint sat_min(input dconf_t c);
    if (c.sign) return -(64'sd1 <<< (c.prec - 1));
    return 64'sd0;
  endfunction

endpackage

// File: rtl/p_div_if.sv
// Operand/result handshake bundle of the divider.
// Input side : in_valid, in_ready, in1 (dividend), in2 (divisor).
// Output side: out_valid, out_ready, out (quotient), udf/ovf/rounded/dbz flags.
// slave = divider side, master = producer/consumer side.
interface p_div_if
  import p_div_pkg::*;
#(
  parameter dconf_t I1_CONF = DEF_I1_CONF,
  parameter dconf_t I2_CONF = DEF_I2_CONF,
  parameter dconf_t O_CONF  = DEF_O_CONF
);
  logic                      in_valid;
  logic                      in_ready;
  logic [I1_CONF.prec-1:0]   in1;
  logic [I2_CONF.prec-1:0]   in2;
  logic                      out_valid;
  logic                      out_ready;
  logic [O_CONF.prec-1:0]    out;
  logic                      udf;
  logic                      ovf;
  logic                      rounded;
  logic                      dbz;

  modport slave (
    input  in_valid, in1, in2, out_ready,
    output in_ready, out_valid, out, udf, ovf, rounded, dbz
  );

  modport master (
    output in_valid, in1, in2, out_ready,
    input  in_ready, out_valid, out, udf, ovf, rounded, dbz
  );
endinterface

// File: rtl/p_sat.sv
// Combinational saturation of a signed raw value into format O_CONF.
// Ports: i_q (signed raw value, QW bits) -> o_out_c (clamped value, O.prec bits),
//        o_ovf_c (value was outside the O range and got clamped).
module p_sat
  import p_div_pkg::*;
#(
  parameter int unsigned QW     = 15,
  parameter dconf_t      O_CONF = DEF_O_CONF
) (
  input  logic signed [QW-1:0]          i_q,
  output logic        [O_CONF.prec-1:0] o_out_c,
  output logic                          o_ovf_c
);
  localparam int unsigned OW    = O_CONF.prec;
  localparam longint      O_MAX = sat_max(O_CONF);
  localparam longint      O_MIN = sat_min(O_CONF);

  if (QW > 64) begin : g_bad_qw
    $error("p_sat: QW must not exceed 64");
  end

  logic signed [63:0] w_q;

  // Size cast keeps signedness, so this sign-extends.
  assign w_q = 64'(i_q);

  // Clamp to the nearest representable bound.
  always_comb begin
    o_out_c = w_q[OW-1:0];
    o_ovf_c = 1'b0;
    if (w_q > O_MAX) begin
      o_out_c = OW'(O_MAX);
      o_ovf_c = 1'b1;
    end else if (w_q < O_MIN) begin
      o_out_c = OW'(O_MIN);
      o_ovf_c = 1'b1;
    end
  end
endmodule

// File: rtl/p_div.sv
// Iterative restoring divider, out = in1 / in2, one quotient bit per cycle.
// Ports: clk, reset (sync, active high), bus (p_div_if.slave: operand
// handshake in, result + udf/ovf/rounded/dbz handshake out).
// Flow: IDLE (accept) -> CALC (N steps) -> FIX (sign + saturate) -> DONE.
module p_div
  import p_div_pkg::*;
#(
  parameter dconf_t I1_CONF = DEF_I1_CONF,
  parameter dconf_t I2_CONF = DEF_I2_CONF,
  parameter dconf_t O_CONF  = DEF_O_CONF
) (
  input  logic      clk,
  input  logic      reset,
  p_div_if.slave    bus
);
  localparam int unsigned I1W  = I1_CONF.prec;
  localparam int unsigned I2W  = I2_CONF.prec;
  localparam int unsigned OW   = O_CONF.prec;
  localparam int          SH_I = int'(O_CONF.frac) - int'(I1_CONF.frac) + int'(I2_CONF.frac);
  localparam int unsigned SH   = (SH_I < 0) ? 0 : unsigned'(SH_I);
  localparam int unsigned N    = I1W + SH;
  localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned QW   = N + 1;
  localparam int unsigned RW   = I2W + 1;

  localparam logic [OW-1:0] O_MAX_V = OW'(sat_max(O_CONF));
  localparam logic [OW-1:0] O_MIN_V = OW'(sat_min(O_CONF));

  if (SH_I < 0) begin : g_bad_sh
    $error("p_div: O.frac - I1.frac + I2.frac must be >= 0");
  end
  if (O_CONF.dtype != INT && O_CONF.dtype != FXP) begin : g_bad_odt
    $error("p_div: O_CONF dtype must be INT or FXP");
  end
  if (N < 2) begin : g_bad_n
    $error("p_div: at least two iteration cycles required");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             w_accept, w_step, w_fix;

  logic [N-1:0]     r_dq;     // dividend shifts out of the top, quotient in at the bottom
  logic [I2W-1:0]   r_dvs;    // divisor magnitude
  logic [I2W-1:0]   r_rem;    // partial remainder, always < divisor
  logic [CW-1:0]    r_cnt;
  logic             r_neg;    // quotient sign
  logic             r_neg1;   // dividend sign, picks the dbz saturation bound
  logic             r_nz1;    // dividend nonzero
  logic             r_dz;     // divide by zero

  logic             r_in_ready, r_out_valid;
  logic [OW-1:0]    r_out;
  logic             r_udf, r_ovf, r_rounded, r_dbz;

  logic             w_s1, w_s2;
  logic [I1W-1:0]   w_m1;
  logic [I2W-1:0]   w_m2;
  logic             w_z2;
  logic [RW-1:0]    w_rem_sh;
  logic             w_ge;
  logic [I2W-1:0]   w_rem_nxt;
  logic signed [QW-1:0] w_q_s;
  logic [OW-1:0]    w_sat_out;
  logic             w_sat_ovf;
  logic [OW-1:0]    w_dbz_out;

  // Operand magnitudes; the most negative value maps to 2^(prec-1), which still fits unsigned.
  assign w_s1 = I1_CONF.sign & bus.in1[I1W-1];
  assign w_s2 = I2_CONF.sign & bus.in2[I2W-1];
  assign w_m1 = w_s1 ? -bus.in1 : bus.in1;
  assign w_m2 = w_s2 ? -bus.in2 : bus.in2;
  assign w_z2 = (bus.in2 == '0);

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  assign w_rem_sh  = {r_rem, r_dq[N-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? I2W'(w_rem_sh - {1'b0, r_dvs}) : w_rem_sh[I2W-1:0];

  // Signed quotient fed to the range check.
  assign w_q_s     = r_neg ? -$signed({1'b0, r_dq}) : $signed({1'b0, r_dq});
  assign w_dbz_out = r_neg1 ? O_MIN_V : O_MAX_V;

  p_sat #(
    .QW     (QW),
    .O_CONF (O_CONF)
  ) u_sat (
    .i_q     (w_q_s),
    .o_out_c (w_sat_out),
    .o_ovf_c (w_sat_ovf)
  );

  // Next-state and per-state strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_fix       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_z2 ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        w_step = 1'b1;
        if (r_cnt == '0) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        w_fix       = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_udf       <= 1'b0;
      r_ovf       <= 1'b0;
      r_rounded   <= 1'b0;
      r_dbz       <= 1'b0;
      r_dq        <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_neg       <= 1'b0;
      r_neg1      <= 1'b0;
      r_nz1       <= 1'b0;
      r_dz        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);

      if (w_accept) begin
        r_dq   <= N'(w_m1) << SH;
        r_dvs  <= w_m2;
        r_rem  <= '0;
        r_cnt  <= CW'(N - 1);
        r_neg  <= w_s1 ^ w_s2;
        r_neg1 <= w_s1;
        r_nz1  <= (w_m1 != '0);
        r_dz   <= w_z2;
      end

      if (w_step) begin
        r_dq  <= {r_dq[N-2:0], w_ge};
        r_rem <= w_rem_nxt;
        r_cnt <= r_cnt - CW'(1);
      end

      if (w_fix) begin
        r_dbz     <= r_dz;
        r_rounded <= (r_rem != '0);
        r_udf     <= r_nz1 && (r_dq == '0) && !r_dz;
        if (r_dz) begin
          r_ovf <= 1'b1;
          r_out <= w_dbz_out;
        end else begin
          r_ovf <= w_sat_ovf;
          r_out <= w_sat_out;
        end
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out       = r_out;
  assign bus.udf       = r_udf;
  assign bus.ovf       = r_ovf;
  assign bus.rounded   = r_rounded;
  assign bus.dbz       = r_dbz;
endmodule
